// File: rtl/multi_way_fetch.sv
// N-way instruction fetch front end: round-robin sharing of one request/dataOk
// memory port, with a per-way PC, jump redirect and instruction FIFO.
module multi_way_fetch #(
    parameter int                NUM_WAYS   = 2,
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         mem_request_o,
    output logic [ADDR_W-1:0]            mem_instAddr_o,
    input  logic [INST_W-1:0]            mem_inst_i,
    input  logic                         mem_dataOk_i,
    input  logic [NUM_WAYS-1:0]          jumpFlag_i,
    input  logic [NUM_WAYS*ADDR_W-1:0]   jumpAddr_i,
    output logic [NUM_WAYS*INST_W-1:0]   inst_o,
    output logic [NUM_WAYS*ADDR_W-1:0]   instAddr_o,
    output logic [NUM_WAYS-1:0]          valid_o,
    input  logic [NUM_WAYS-1:0]          ready_i
);

    localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_W / 8);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                           state_q, state_d;
    logic   [PTR_W-1:0]               rr_ptr, owner, grant_idx, cand;
    logic                             grant_vld;
    logic                             stale;
    logic   [ADDR_W-1:0]              addr_q;
    int                               arb_idx;
    logic   [NUM_WAYS-1:0]            eligible, push, pop;
    logic   [NUM_WAYS-1:0][ADDR_W-1:0] pc_all;

    // Round-robin search for the first eligible way starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        arb_idx   = 0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NUM_WAYS;
            cand    = PTR_W'(arb_idx);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld)    state_d = WAIT;
            WAIT:    if (mem_dataOk_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_request_o  = (state_q == WAIT);
        mem_instAddr_o = addr_q;
    end

    // A jump on the owning way while waiting marks the in-flight response stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            owner  <= '0;
            addr_q <= '0;
            stale  <= 1'b0;
        end else if (state_q == IDLE && grant_vld) begin
            addr_q <= pc_all[grant_idx];
            owner  <= grant_idx;
            stale  <= 1'b0;
            rr_ptr <= (grant_idx == PTR_W'(NUM_WAYS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (state_q == WAIT && jumpFlag_i[owner]) begin
            stale <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
        logic [ADDR_W-1:0] pc_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [IDX_W-1:0]  rd_q, wr_q;
        logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
        logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];

        assign pc_all[i]   = pc_q;
        assign eligible[i] = (cnt_q < CNT_W'(FIFO_DEPTH)) && !jumpFlag_i[i];
        assign push[i]     = (state_q == WAIT) && mem_dataOk_i && !stale &&
                             !jumpFlag_i[i] && (owner == PTR_W'(i));
        assign pop[i]      = (cnt_q != '0) && ready_i[i] && !jumpFlag_i[i];

        // A jump flushes the FIFO and redirects the PC in the same edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pc_q  <= RESET_PC;
                cnt_q <= '0;
                rd_q  <= '0;
                wr_q  <= '0;
            end else if (jumpFlag_i[i]) begin
                pc_q  <= jumpAddr_i[i*ADDR_W +: ADDR_W];
                cnt_q <= '0;
                rd_q  <= '0;
                wr_q  <= '0;
            end else begin
                if (push[i]) begin
                    pc_q <= pc_q + PC_INC;
                    wr_q <= wr_q + 1'b1;
                end
                if (pop[i]) rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) begin
                fifo_pc[wr_q]   <= pc_q;
                fifo_inst[wr_q] <= mem_inst_i;
            end
        end

        // Storage is not reset, so the head is masked while the FIFO is empty.
        assign valid_o[i]                     = (cnt_q != '0);
        assign inst_o[i*INST_W +: INST_W]     = (cnt_q != '0) ? fifo_inst[rd_q] : '0;
        assign instAddr_o[i*ADDR_W +: ADDR_W] = (cnt_q != '0) ? fifo_pc[rd_q] : '0;
    end

endmodule

// File: tb/tb_multi_way_fetch.sv
// Directed bench for multi_way_fetch: a 2-way and a 4-way instance served by
// a scripted memory that returns addr ^ K as the instruction word.
module tb_multi_way_fetch;

    localparam logic [31:0] K = 32'hC0DE_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_a, ok_a;
    logic [31:0] maddr_a, minst_a;
    logic [1:0]  jf_a, vld_a, rdy_a;
    logic [63:0] ja_a, inst_a, iaddr_a;

    logic         req_b, ok_b;
    logic [31:0]  maddr_b, minst_b;
    logic [3:0]   jf_b, vld_b, rdy_b;
    logic [127:0] ja_b, inst_b, iaddr_b;

    int n_checks = 0;
    int n_fail   = 0;

    multi_way_fetch #(.NUM_WAYS(2)) dut_a (
        .clk(clk), .reset(reset),
        .mem_request_o(req_a), .mem_instAddr_o(maddr_a),
        .mem_inst_i(minst_a), .mem_dataOk_i(ok_a),
        .jumpFlag_i(jf_a), .jumpAddr_i(ja_a),
        .inst_o(inst_a), .instAddr_o(iaddr_a),
        .valid_o(vld_a), .ready_i(rdy_a)
    );

    multi_way_fetch #(.NUM_WAYS(4)) dut_b (
        .clk(clk), .reset(reset),
        .mem_request_o(req_b), .mem_instAddr_o(maddr_b),
        .mem_inst_i(minst_b), .mem_dataOk_i(ok_b),
        .jumpFlag_i(jf_b), .jumpAddr_i(ja_b),
        .inst_o(inst_b), .instAddr_o(iaddr_b),
        .valid_o(vld_b), .ready_i(rdy_b)
    );

    task automatic clear_inputs();
        ok_a = 0; ok_b = 0; jf_a = 0; jf_b = 0; ja_a = 0; ja_b = 0;
        minst_a = 0; minst_b = 0; rdy_a = 0; rdy_b = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_req_a(output logic [31:0] a);
        int w = 0;
        while (req_a !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        n_checks++;
        if (req_a !== 1'b1) begin n_fail++; $display("FAIL wait_req_a: request=%b required 1 within 50 cycles", req_a); end
        a = maddr_a;
    endtask

    task automatic wait_req_b(output logic [31:0] a);
        int w = 0;
        while (req_b !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        n_checks++;
        if (req_b !== 1'b1) begin n_fail++; $display("FAIL wait_req_b: request=%b required 1 within 50 cycles", req_b); end
        a = maddr_b;
    endtask

    task automatic serve_a(input int lat, output logic [31:0] a);
        wait_req_a(a);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_a !== 1'b1 || maddr_a !== a) begin n_fail++; $display("FAIL hold_a: req=%b addr=%h required 1/%h", req_a, maddr_a, a); end
        end
        ok_a = 1; minst_a = a ^ K;
        @(negedge clk);
        ok_a = 0;
    endtask

    task automatic serve_b(input int lat, output logic [31:0] a);
        wait_req_b(a);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_b !== 1'b1 || maddr_b !== a) begin n_fail++; $display("FAIL hold_b: req=%b addr=%h required 1/%h", req_b, maddr_b, a); end
        end
        ok_b = 1; minst_b = a ^ K;
        @(negedge clk);
        ok_b = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        @(negedge clk);
        n_checks++; if (req_a !== 1'b0)    begin n_fail++; $display("FAIL reset_req_a: got %b required 0", req_a); end
        n_checks++; if (maddr_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr_a: got %h required 0", maddr_a); end
        n_checks++; if (vld_a !== 2'b00)   begin n_fail++; $display("FAIL reset_valid_a: got %b required 00", vld_a); end
        n_checks++; if (inst_a !== 64'h0)  begin n_fail++; $display("FAIL reset_inst_a: got %h required 0", inst_a); end
        n_checks++; if (iaddr_a !== 64'h0) begin n_fail++; $display("FAIL reset_iaddr_a: got %h required 0", iaddr_a); end
        n_checks++; if (req_b !== 1'b0)    begin n_fail++; $display("FAIL reset_req_b: got %b required 0", req_b); end
        n_checks++; if (vld_b !== 4'b0000) begin n_fail++; $display("FAIL reset_valid_b: got %b required 0000", vld_b); end
        reset = 0;
    endtask

    task automatic test_alternate();
        logic [31:0] a;
        logic [31:0] exp_addr [4] = '{32'h0, 32'h0, 32'h4, 32'h4};
        logic [1:0]  exp_vld  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] head;
        do_reset();
        rdy_a = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve_a(1, a);
            head = (k % 2 == 0) ? iaddr_a[31:0] : iaddr_a[63:32];
            n_checks++; if (a !== exp_addr[k])       begin n_fail++; $display("FAIL alt_addr[%0d]: got %h required %h", k, a, exp_addr[k]); end
            n_checks++; if (vld_a !== exp_vld[k])    begin n_fail++; $display("FAIL alt_valid[%0d]: got %b required %b", k, vld_a, exp_vld[k]); end
            n_checks++; if (head !== exp_addr[k])    begin n_fail++; $display("FAIL alt_head[%0d]: got %h required %h", k, head, exp_addr[k]); end
        end
        n_checks++; if (inst_a[63:32] !== (32'h4 ^ K)) begin n_fail++; $display("FAIL alt_inst1: got %h required %h", inst_a[63:32], 32'h4 ^ K); end
    endtask

    task automatic test_fill();
        logic [31:0] a;
        int hi;
        do_reset();
        rdy_a = 2'b00;
        for (int k = 0; k < 8; k++) begin
            serve_a(1, a);
            n_checks++; if (a !== 32'(4 * (k / 2))) begin n_fail++; $display("FAIL fill_addr[%0d]: got %h required %h", k, a, 32'(4 * (k / 2))); end
        end
        n_checks++; if (vld_a !== 2'b11)   begin n_fail++; $display("FAIL fill_valid: got %b required 11", vld_a); end
        n_checks++; if (iaddr_a !== 64'h0) begin n_fail++; $display("FAIL fill_heads: got %h required 0", iaddr_a); end
        hi = 0;
        repeat (8) begin @(negedge clk); if (req_a) hi++; end
        n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL full_no_req: got %0d request cycles required 0", hi); end
        rdy_a = 2'b10;
        @(negedge clk);
        rdy_a = 2'b00;
        n_checks++; if (iaddr_a[63:32] !== 32'h4)    begin n_fail++; $display("FAIL pop1_head: got %h required 4", iaddr_a[63:32]); end
        n_checks++; if (inst_a[63:32] !== (32'h4 ^ K)) begin n_fail++; $display("FAIL pop1_inst: got %h required %h", inst_a[63:32], 32'h4 ^ K); end
        serve_a(1, a);
        n_checks++; if (a !== 32'h10) begin n_fail++; $display("FAIL resume_addr: got %h required 10", a); end
        n_checks++; if (vld_a !== 2'b11 || iaddr_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL way0_untouched: valid=%b head=%h required 11/0", vld_a, iaddr_a[31:0]); end
        hi = 0;
        repeat (8) begin @(negedge clk); if (req_a) hi++; end
        n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL refull_no_req: got %0d request cycles required 0", hi); end
    endtask

    task automatic test_jump_stale();
        logic [31:0] a;
        do_reset();
        rdy_a = 2'b11;
        repeat (4) serve_a(1, a);
        wait_req_a(a);
        n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL stale_req_addr: got %h required 8", a); end
        jf_a = 2'b01; ja_a[31:0] = 32'h100;
        @(negedge clk);
        jf_a = 2'b00;
        @(negedge clk);
        ok_a = 1; minst_a = 32'hDEAD_BEEF;
        @(negedge clk);
        ok_a = 0;
        n_checks++; if (vld_a !== 2'b00) begin n_fail++; $display("FAIL stale_dropped: valid=%b required 00", vld_a); end
        serve_a(1, a);
        n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL stale_way1_addr: got %h required 8", a); end
        n_checks++; if (vld_a !== 2'b10 || iaddr_a[63:32] !== 32'h8) begin n_fail++; $display("FAIL stale_way1_out: valid=%b head=%h required 10/8", vld_a, iaddr_a[63:32]); end
        serve_a(1, a);
        n_checks++; if (a !== 32'h100) begin n_fail++; $display("FAIL stale_redirect: got %h required 100", a); end
        n_checks++; if (vld_a !== 2'b01 || iaddr_a[31:0] !== 32'h100) begin n_fail++; $display("FAIL stale_way0_out: valid=%b head=%h required 01/100", vld_a, iaddr_a[31:0]); end
    endtask

    task automatic test_jump_on_dataok();
        logic [31:0] a;
        do_reset();
        rdy_a = 2'b00;
        repeat (4) serve_a(1, a);
        wait_req_a(a);
        n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL jd_req_addr: got %h required 8", a); end
        ok_a = 1; minst_a = 32'h1234_5678;
        jf_a = 2'b01; ja_a[31:0] = 32'h200; rdy_a = 2'b01;
        @(negedge clk);
        ok_a = 0; jf_a = 2'b00; rdy_a = 2'b00;
        n_checks++; if (vld_a !== 2'b10) begin n_fail++; $display("FAIL jd_flush: valid=%b required 10", vld_a); end
        n_checks++; if (iaddr_a[63:32] !== 32'h0) begin n_fail++; $display("FAIL jd_way1_head: got %h required 0", iaddr_a[63:32]); end
        serve_a(1, a);
        n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL jd_way1_addr: got %h required 8", a); end
        serve_a(1, a);
        n_checks++; if (a !== 32'h200) begin n_fail++; $display("FAIL jd_redirect: got %h required 200", a); end
        n_checks++; if (vld_a !== 2'b11 || iaddr_a[31:0] !== 32'h200) begin n_fail++; $display("FAIL jd_way0_out: valid=%b head=%h required 11/200", vld_a, iaddr_a[31:0]); end
        n_checks++; if (inst_a[31:0] !== (32'h200 ^ K)) begin n_fail++; $display("FAIL jd_way0_inst: got %h required %h", inst_a[31:0], 32'h200 ^ K); end
    endtask

    task automatic test_four_way();
        logic [31:0] a;
        logic [31:0] exp;
        int          order [4] = '{1, 2, 3, 0};
        logic [31:0] base  [4] = '{32'h1000, 32'h0, 32'h2000, 32'h0};
        logic [31:0] tail  [4] = '{32'h2010, 32'h1010, 32'h2014, 32'h1014};
        @(negedge clk);
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
        jf_b = 4'b0101; ja_b[31:0] = 32'h1000; ja_b[95:64] = 32'h2000;
        rdy_b = 4'b0101;
        @(negedge clk);
        jf_b = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            serve_b(5, a);
            exp = base[order[k % 4]] + 32'(4 * (k / 4));
            n_checks++; if (a !== exp) begin n_fail++; $display("FAIL four_rot[%0d]: got %h required %h", k, a, exp); end
        end
        n_checks++; if (vld_b[3] !== 1'b1 || vld_b[1] !== 1'b1) begin n_fail++; $display("FAIL four_full: valid=%b required 1x1x", vld_b); end
        for (int k = 0; k < 4; k++) begin
            serve_b(5, a);
            n_checks++; if (a !== tail[k]) begin n_fail++; $display("FAIL four_alt[%0d]: got %h required %h", k, a, tail[k]); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a;
        do_reset();
        rdy_a = 2'b00;
        wait_req_a(a);
        n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL rw_first_addr: got %h required 0", a); end
        reset = 1;
        #1;
        n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL rw_async: request=%b required 0", req_a); end
        repeat (2) @(negedge clk);
        reset = 0;
        ok_a = 1; minst_a = 32'hBAD0_0000;
        @(negedge clk);
        ok_a = 0;
        n_checks++; if (req_a !== 1'b1 || maddr_a !== 32'h0) begin n_fail++; $display("FAIL rw_new_req: req=%b addr=%h required 1/0", req_a, maddr_a); end
        n_checks++; if (vld_a !== 2'b00) begin n_fail++; $display("FAIL rw_ignored: valid=%b required 00", vld_a); end
        serve_a(1, a);
        n_checks++; if (vld_a !== 2'b01 || iaddr_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL rw_push: valid=%b head=%h required 01/0", vld_a, iaddr_a[31:0]); end
        n_checks++; if (inst_a[31:0] !== K) begin n_fail++; $display("FAIL rw_inst: got %h required %h", inst_a[31:0], K); end
        rdy_a = 2'b01;
        @(negedge clk);
        rdy_a = 2'b00;
        n_checks++; if (vld_a[0] !== 1'b0) begin n_fail++; $display("FAIL rw_single_entry: valid0=%b required 0", vld_a[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alternate();
        test_fill();
        test_jump_stale();
        test_jump_on_dataok();
        test_four_way();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
